// File: rtl/mpeg_mv_pkg.sv
// mpeg_mv_pkg: shared motion_code VLC prefix/length table and encoder FSM states
package mpeg_mv_pkg;
  localparam int MV_MAX = 16;
  localparam int MV_CODE_MAXLEN = 11;
  localparam logic [9:0] MV_PREFIX [0:MV_MAX] = '{
    10'd1, 10'd1, 10'd1, 10'd1, 10'd3, 10'd5, 10'd4, 10'd3, 10'd11,
    10'd10, 10'd9, 10'd17, 10'd16, 10'd15, 10'd14, 10'd13, 10'd12
  };
  localparam logic [3:0] MV_PLEN [0:MV_MAX] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd7, 4'd7, 4'd9,
    4'd9, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10
  };
  typedef enum logic {RUN, FLUSH} enc_state_t;
endpackage

// File: rtl/motion_code_vlc_lut.sv
// motion_code_vlc_lut: magnitude/sign to right-aligned VLC codeword and length
module motion_code_vlc_lut
  import mpeg_mv_pkg::*;
(
  input  logic [5:0]  mag,
  input  logic        sign,
  output logic [3:0]  len,
  output logic [10:0] code,
  output logic        range_err
);
  logic [4:0] idx;
  // zero magnitude has no sign bit; out-of-range codes emit nothing
  always_comb begin
    range_err = mag > 6'(MV_MAX);
    idx = range_err ? 5'd0 : mag[4:0];
    code = range_err ? 11'd0 : mag == 6'd0 ? 11'd1 : {MV_PREFIX[idx], sign};
    len = range_err ? 4'd0 : mag == 6'd0 ? 4'd1 : MV_PLEN[idx] + 4'd1;
  end
endmodule

// File: rtl/motion_code_encoder.sv
// motion_code_encoder: packs motion_code VLCs MSB-first into WORD_W-bit words
module motion_code_encoder
  import mpeg_mv_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        mcode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              flush_done,
  output logic              err
);
  localparam int AW = WORD_W + 10;
  localparam int CW = $clog2(WORD_W + 11);
  enc_state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, placed;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d;
  logic [5:0] mag;
  logic [3:0] len;
  logic [10:0] code, code_l;
  logic range_err, accept, emit;
  assign mag = mcode[5] ? -mcode : mcode;
  motion_code_vlc_lut u_lut (
    .mag       (mag),
    .sign      (mcode[5]),
    .len       (len),
    .code      (code),
    .range_err (range_err)
  );
  assign out_valid = count_q >= CW'(WORD_W);
  assign in_ready = state_q == RUN && !out_valid;
  assign out_word = acc_q[AW-1 -: WORD_W];
  assign flush_done = state_q == FLUSH && count_q == '0;
  assign err = err_q;
  assign accept = in_valid && in_ready;
  assign emit = out_valid && out_ready;
  // append accepted code below the valid bits, drain words, and pad on flush
  always_comb begin
    acc_d = acc_q;
    count_d = count_q;
    state_d = state_q;
    err_d = 1'b0;
    code_l = code << (4'd11 - len);
    placed = {code_l, {(AW-11){1'b0}}} >> count_q;
    if (accept) begin
      acc_d = acc_q | placed;
      count_d = count_q + CW'(len);
      err_d = range_err;
    end
    if (emit) begin
      acc_d = acc_q << WORD_W;
      count_d = count_q - CW'(WORD_W);
    end
    if (state_q == RUN && in_ready && flush) state_d = FLUSH;
    if (state_q == FLUSH && !out_valid) begin
      if (count_q != '0) count_d = CW'(WORD_W);
      else state_d = RUN;
    end
  end
  // state register with asynchronous clear of all pending bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      acc_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_motion_code_encoder.sv
// tb_motion_code_encoder: directed self-checking bench for motion_code_encoder
module tb_motion_code_encoder;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0;
  logic out_valid, out_ready = 1, flush_done, err;
  logic [5:0] mcode = 0;
  logic [15:0] out_word;
  int errors = 0, checks = 0;
  motion_code_encoder #(.WORD_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mcode(mcode), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .flush_done(flush_done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [5:0] c);
    in_valid = 1;
    mcode = c;
    step();
    in_valid = 0;
  endtask
  initial begin
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", dut.count_q, 0);
    rst = 0;
    step();
    in_valid = 1;
    mcode = 0;
    repeat (16) step();
    in_valid = 0;
    chk("ones_valid", out_valid, 1);
    chk("ones_word", out_word, 16'hFFFF);
    chk("ones_in_ready", in_ready, 0);
    step();
    chk("ones_drained", out_valid, 0);
    chk("ones_ready_after", in_ready, 1);
    chk("ones_count", dut.count_q, 0);
    send(6'd3);
    chk("p3_no_word", out_valid, 0);
    send(6'h30);
    chk("m16_valid", out_valid, 1);
    chk("m16_word", out_word, 16'h1019);
    step();
    chk("m16_count", dut.count_q, 0);
    send(6'd16);
    send(6'd16);
    chk("pp16_valid", out_valid, 1);
    chk("pp16_word0", out_word, 16'h0300);
    step();
    chk("pp16_in_ready", in_ready, 1);
    chk("pp16_drain", out_valid, 0);
    flush = 1;
    step();
    flush = 0;
    chk("fl_in_ready", in_ready, 0);
    chk("fl_no_word_yet", out_valid, 0);
    step();
    chk("fl_pad_valid", out_valid, 1);
    chk("fl_word1", out_word, 16'h6000);
    chk("fl_not_done", flush_done, 0);
    step();
    chk("fl_done", flush_done, 1);
    chk("fl_done_nowrd", out_valid, 0);
    step();
    chk("fl_done_pulse", flush_done, 0);
    chk("fl_back_run", in_ready, 1);
    out_ready = 0;
    in_valid = 1;
    mcode = 0;
    repeat (16) step();
    in_valid = 0;
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_word", out_word, 16'hFFFF);
      chk("bp_hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1;
    step();
    chk("bp_released", out_valid, 0);
    chk("bp_ready_after", in_ready, 1);
    send(6'd17);
    chk("err_p17", err, 1);
    chk("err_p17_count", dut.count_q, 0);
    step();
    chk("err_p17_pulse", err, 0);
    send(6'h2F);
    chk("err_m17", err, 1);
    chk("err_m17_count", dut.count_q, 0);
    chk("err_m17_nowrd", out_valid, 0);
    step();
    chk("err_m17_pulse", err, 0);
    send(6'd4);
    chk("rs_count7", dut.count_q, 7);
    #2 rst = 1;
    #1;
    chk("rs_async_count", dut.count_q, 0);
    chk("rs_async_word", out_word, 0);
    chk("rs_async_ready", in_ready, 1);
    #1 rst = 0;
    flush = 1;
    step();
    flush = 0;
    chk("rs_flush_done", flush_done, 1);
    chk("rs_no_word", out_valid, 0);
    chk("rs_no_err", err, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rs_quiet_done", flush_done, 0);
      chk("rs_quiet_valid", out_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
